// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard unit: forwarding, load-use and branch stall/flush, post-reset flush window, data-memory wait freeze; HAZARD_PERF_EN adds perf counters
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_WAIT     = 15,
    parameter int CNT_W        = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] Rs1D,
    input  logic [4:0] Rs2D,
    input  logic [4:0] Rs1E,
    input  logic [4:0] Rs2E,
    input  logic [4:0] RdE,
    input  logic [4:0] RdM,
    input  logic [4:0] RdW,
    input  logic       PCSrcE,
    input  logic       ResultSrcEb0,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemBusyM,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       MemTimeout
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] LuStallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] WaitCnt
`endif
);

    localparam int IW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(FLUSH_CYCLES - 1);
    localparam logic [WW-1:0] WAIT_MAX  = WW'(MAX_WAIT);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_WAIT} state_t;

    state_t        state;
    state_t        nextState;
    logic [IW-1:0] initCnt;
    logic [WW-1:0] waitCnt;
    logic [WW-1:0] waitNext;
    logic          lwStall;
    logic          memWait;
    logic          runActive;

    // Forwarding: Memory stage wins over Writeback; x0 never forwards; held at 00 while in reset
    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (reset) begin
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs1E))      ForwardAE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs1E)) ForwardAE = 2'b01;
            if (RegWriteM && (RdM != 5'd0) && (RdM == Rs2E))      ForwardBE = 2'b10;
            else if (RegWriteW && (RdW != 5'd0) && (RdW == Rs2E)) ForwardBE = 2'b01;
        end
    end

    // Next state and steering; a busy memory freezes the pipe in the same cycle it is seen
    always_comb begin
        nextState = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        StallM    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushW    = 1'b0;
        lwStall   = ResultSrcEb0 && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
        memWait   = (state != S_INIT) && MemBusyM;
        runActive = (state != S_INIT) && !MemBusyM;
        waitNext  = (state == S_WAIT) ? ((waitCnt == WAIT_MAX) ? waitCnt : waitCnt + WW'(1))
                                      : WW'(1);
        case (state)
            S_RUN, S_WAIT: begin
                if (MemBusyM) begin
                    StallF    = 1'b1;
                    StallD    = 1'b1;
                    StallE    = 1'b1;
                    StallM    = 1'b1;
                    FlushW    = 1'b1;
                    nextState = S_WAIT;
                end else begin
                    StallF    = lwStall;
                    StallD    = lwStall;
                    FlushD    = PCSrcE;
                    FlushE    = lwStall || PCSrcE;
                    nextState = S_RUN;
                end
            end
            default: begin
                FlushD = 1'b1;
                FlushE = 1'b1;
                if (initCnt == INIT_LAST) nextState = S_RUN;
                else                      nextState = S_INIT;
            end
        endcase
    end

    // State, flush-window counter, per-episode wait counter and sticky timeout
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_INIT;
            initCnt    <= '0;
            waitCnt    <= '0;
            MemTimeout <= 1'b0;
        end else begin
            state <= nextState;
            if ((state == S_INIT) && (initCnt != INIT_LAST)) initCnt <= initCnt + IW'(1);
            if (memWait) begin
                waitCnt <= waitNext;
                if (waitNext == WAIT_MAX) MemTimeout <= 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    // Saturating event counters for load-use stalls, branch flushes and memory wait cycles
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            LuStallCnt <= '0;
            FlushCnt   <= '0;
            WaitCnt    <= '0;
        end else begin
            if (runActive && lwStall && (LuStallCnt != '1)) LuStallCnt <= LuStallCnt + CNT_W'(1);
            if (runActive && PCSrcE && (FlushCnt != '1))    FlushCnt   <= FlushCnt + CNT_W'(1);
            if (memWait && (WaitCnt != '1))                 WaitCnt    <= WaitCnt + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl: vector table, corner sequences, randomized run against a reference model
module tb_hazard_ctrl;

    localparam int FLUSH_CYCLES = 2;
    localparam int MAX_WAIT     = 15;
    localparam int CNT_W        = 32;

    logic       clk = 1'b0;
    logic       rstN;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW, MemBusyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, MemTimeout;
    logic [1:0] ForwardAE, ForwardBE;
`ifdef HAZARD_PERF_EN
    logic [CNT_W-1:0] LuStallCnt, FlushCnt, WaitCnt;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state: cycles left in the flush window, current busy run length, sticky timeout
    int initLeft;
    int busyRun;
    bit mTimeout;
    longint mLu, mFl, mWait;

    hazard_ctrl #(.FLUSH_CYCLES(FLUSH_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(rstN),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .PCSrcE(PCSrcE), .ResultSrcEb0(ResultSrcEb0),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemBusyM(MemBusyM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE), .MemTimeout(MemTimeout)
`ifdef HAZARD_PERF_EN
        , .LuStallCnt(LuStallCnt), .FlushCnt(FlushCnt), .WaitCnt(WaitCnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
        logic       pcSrc, load, regWM, regWW;
        logic [7:0] expOut;  // {StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] fwdOf(input logic [4:0] rs);
        if (!rstN) return 2'b00;
        if (RegWriteM && RdM != 0 && RdM == rs) return 2'b10;
        if (RegWriteW && RdW != 0 && RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [11:0] dutOut();
        return {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, ForwardAE, ForwardBE, MemTimeout};
    endfunction

    task automatic checkNow(input string tag);
        logic sF, sD, sE, sM, fD, fE, fW, lw, to;
        {sF, sD, sE, sM, fD, fE, fW} = '0;
        if (!rstN || initLeft > 0) begin
            fD = 1'b1;
            fE = 1'b1;
        end else if (MemBusyM) begin
            {sF, sD, sE, sM, fW} = '1;
        end else begin
            lw = ResultSrcEb0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D);
            sF = lw;
            sD = lw;
            fD = PCSrcE;
            fE = lw || PCSrcE;
        end
        to = rstN ? mTimeout : 1'b0;
        check(tag, 64'(dutOut()), 64'({sF, sD, sE, sM, fD, fE, fW, fwdOf(Rs1E), fwdOf(Rs2E), to}));
`ifdef HAZARD_PERF_EN
        check({tag, "_lu"}, 64'(LuStallCnt), 64'(rstN ? mLu : 0));
        check({tag, "_fl"}, 64'(FlushCnt), 64'(rstN ? mFl : 0));
        check({tag, "_wt"}, 64'(WaitCnt), 64'(rstN ? mWait : 0));
`endif
    endtask

    task automatic stepEdge();
        @(posedge clk);
        if (!rstN) begin
            initLeft = FLUSH_CYCLES;
            busyRun  = 0;
            mTimeout = 0;
            mLu = 0; mFl = 0; mWait = 0;
        end else if (initLeft > 0) begin
            initLeft--;
        end else if (MemBusyM) begin
            busyRun++;
            mWait++;
            if (busyRun >= MAX_WAIT) mTimeout = 1;
        end else begin
            busyRun = 0;
            if (ResultSrcEb0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) mLu++;
            if (PCSrcE) mFl++;
        end
        #1;
    endtask

    task automatic cycle(input string tag);
        @(negedge clk);
        checkNow(tag);
        stepEdge();
    endtask

    task automatic idleInputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW, MemBusyM} = '0;
    endtask

    task automatic doReset();
        rstN = 1'b0;
        cycle("rst");
        rstN = 1'b1;
        for (int i = 0; i < FLUSH_CYCLES; i++) cycle("init");
    endtask

    initial begin
        vec_t v;
        //        rs1D rs2D rs1E rs2E rdE rdM rdW pc ld wM wW  {sF sD fD fE fA fB}
        vecs.push_back('{5'd1,  5'd5,  5'd0,  5'd0,  5'd5, 5'd0,  5'd0,  0, 1, 0, 0, 8'b1101_0000});
        vecs.push_back('{5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  0, 1, 0, 0, 8'b0000_0000});
        vecs.push_back('{5'd0,  5'd0,  5'd7,  5'd3,  5'd0, 5'd7,  5'd7,  0, 0, 1, 1, 8'b0000_1000});
        vecs.push_back('{5'd0,  5'd0,  5'd7,  5'd3,  5'd0, 5'd7,  5'd7,  0, 0, 0, 1, 8'b0000_0100});
        vecs.push_back('{5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  0, 0, 1, 1, 8'b0000_0000});
        vecs.push_back('{5'd9,  5'd2,  5'd0,  5'd0,  5'd9, 5'd0,  5'd0,  1, 1, 0, 0, 8'b1111_0000});
        vecs.push_back('{5'd0,  5'd0,  5'd4,  5'd12, 5'd0, 5'd12, 5'd12, 0, 0, 1, 1, 8'b0000_0010});
        vecs.push_back('{5'd0,  5'd0,  5'd3,  5'd12, 5'd0, 5'd3,  5'd12, 0, 0, 1, 1, 8'b0000_1001});
        vecs.push_back('{5'd5,  5'd0,  5'd0,  5'd0,  5'd5, 5'd0,  5'd0,  0, 0, 0, 0, 8'b0000_0000});
        vecs.push_back('{5'd0,  5'd0,  5'd0,  5'd0,  5'd0, 5'd0,  5'd0,  1, 0, 0, 0, 8'b0011_0000});

        initLeft = FLUSH_CYCLES; busyRun = 0; mTimeout = 0;
        mLu = 0; mFl = 0; mWait = 0;
        idleInputs();
        rstN = 1'b0;

        // Reset held three cycles: only FlushD/FlushE, forwarding suppressed even with a matching writer
        RegWriteM = 1'b1; RdM = 5'd7; Rs1E = 5'd7;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_state", 64'(dutOut()), 64'(12'b0000_110_00_00_0));
            checkNow("reset_model");
            stepEdge();
        end
        idleInputs();
        rstN = 1'b1;

        // Flush window lasts exactly FLUSH_CYCLES cycles after release
        for (int i = 0; i < FLUSH_CYCLES + 1; i++) begin
            @(negedge clk);
            check("init_window", 64'({StallF, StallD, StallE, StallM, FlushD, FlushE}),
                  64'((i < FLUSH_CYCLES) ? 6'b000011 : 6'b000000));
            checkNow("init_model");
            stepEdge();
        end

        // Combinational vector table in the run state
        foreach (vecs[k]) begin
            v = vecs[k];
            {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = {v.rs1D, v.rs2D, v.rs1E, v.rs2E, v.rdE, v.rdM, v.rdW};
            {PCSrcE, ResultSrcEb0, RegWriteM, RegWriteW} = {v.pcSrc, v.load, v.regWM, v.regWW};
            @(negedge clk);
            check($sformatf("vec%0d", k), 64'({StallF, StallD, FlushD, FlushE, ForwardAE, ForwardBE}), 64'(v.expOut));
            checkNow("vec_model");
            stepEdge();
        end

        // Four busy cycles with a taken branch: freeze wins, then the branch flushes on release
        idleInputs();
        PCSrcE = 1'b1;
        MemBusyM = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("wait4_freeze", 64'({StallF, StallD, StallE, StallM, FlushW, FlushD, FlushE}), 64'(7'b1111100));
            checkNow("wait4_model");
            stepEdge();
        end
        MemBusyM = 1'b0;
        @(negedge clk);
        check("wait4_release", 64'({StallE, StallM, FlushW, FlushD, FlushE, MemTimeout}), 64'(6'b000110));
        checkNow("wait4_rel_model");
        stepEdge();

        // Fifteen busy cycles from a fresh reset: timeout becomes sticky, then reset clears it mid-wait
        idleInputs();
        doReset();
        MemBusyM = 1'b1;
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            check("timeout_pre", 64'(MemTimeout), 64'(0));
            checkNow("timeout_model");
            stepEdge();
        end
        MemBusyM = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("timeout_sticky", 64'(MemTimeout), 64'(1));
`ifdef HAZARD_PERF_EN
            check("waitcnt_15", 64'(WaitCnt), 64'(MAX_WAIT));
`endif
            checkNow("sticky_model");
            stepEdge();
        end
        MemBusyM = 1'b1;
        for (int i = 0; i < 3; i++) cycle("rewait");
        rstN = 1'b0;
        @(negedge clk);
        check("reset_midwait", 64'(dutOut()), 64'(12'b0000_110_00_00_0));
        checkNow("midwait_model");
        stepEdge();
        rstN = 1'b1;
        MemBusyM = 1'b0;
        for (int i = 0; i < FLUSH_CYCLES; i++) cycle("init2");

        // Randomized traffic against the model, with occasional resets
        for (int i = 0; i < 600; i++) begin
            Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3)); Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3)); RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            PCSrcE       = ($urandom_range(0, 3) == 0);
            ResultSrcEb0 = ($urandom_range(0, 1) == 0);
            RegWriteM    = ($urandom_range(0, 1) == 0);
            RegWriteW    = ($urandom_range(0, 1) == 0);
            MemBusyM     = (i % 100 > 60) ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            rstN         = ($urandom_range(0, 149) != 0);
            cycle("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
